// File: rtl/speed_sample_sequencer.sv
// Periodic odometry sampler: snapshots x/y positions on a fixed tick and publishes
// saturated per-period deltas over valid/ready, flagging ticks dropped while busy.
//
// state   | meaning
// IDLE    | waiting for sample tick; captures (and primes) on tick
// SUB_X   | shared subtractor computes x delta
// SUB_Y   | shared subtractor computes y delta, prev <= cur
// PUBLISH | loads outputs, holds speed_valid until speed_ready
module speed_sample_sequencer #(
  parameter int TICK_CYCLES = 50000,
  parameter int W           = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic signed [W-1:0] x_Global,
  input  logic signed [W-1:0] y_Global,
  output logic                sample_tick,
  output logic                speed_valid,
  input  logic                speed_ready,
  output logic signed [W-1:0] current_x_speed,
  output logic signed [W-1:0] current_y_speed,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          drop_cnt
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SUB_X, SUB_Y, PUBLISH} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic primed;
  logic signed [W-1:0] cur_x, cur_y, prev_x, prev_y, dx, dy;
  logic signed [W-1:0] sub_a, sub_b, sub_res;
  logic signed [W:0] diff;
  logic capture, load_dx, load_dy, pub_load, pub_done;

  assign sample_tick = enable && (cnt == CNT_LAST);
  assign busy        = (state != IDLE);
  assign overrun     = sample_tick && (state != IDLE);

  // Single subtractor, operands steered by the current axis
  assign sub_a = (state == SUB_Y) ? cur_y  : cur_x;
  assign sub_b = (state == SUB_Y) ? prev_y : prev_x;
  assign diff  = {sub_a[W-1], sub_a} - {sub_b[W-1], sub_b};

  always_comb begin
    sub_res = diff[W-1:0];
    if (diff[W] != diff[W-1])
      sub_res = diff[W] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_dx   = 1'b0;
    load_dy   = 1'b0;
    pub_load  = 1'b0;
    pub_done  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          capture = 1'b1;
          if (primed)
            state_nxt = SUB_X;
        end
      end
      SUB_X: begin
        load_dx   = 1'b1;
        state_nxt = SUB_Y;
      end
      SUB_Y: begin
        load_dy   = 1'b1;
        state_nxt = PUBLISH;
      end
      PUBLISH: begin
        if (!speed_valid)
          pub_load = 1'b1;
        else if (speed_ready) begin
          pub_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!enable || cnt == CNT_LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      primed <= 1'b0;
    else if (!enable)
      primed <= 1'b0;
    else if (capture)
      primed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x  <= '0;
      cur_y  <= '0;
      prev_x <= '0;
      prev_y <= '0;
      dx     <= '0;
      dy     <= '0;
    end else begin
      if (capture) begin
        cur_x <= x_Global;
        cur_y <= y_Global;
        if (!primed) begin
          prev_x <= x_Global;
          prev_y <= y_Global;
        end
      end
      if (load_dx)
        dx <= sub_res;
      if (load_dy) begin
        dy     <= sub_res;
        prev_x <= cur_x;
        prev_y <= cur_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_valid     <= 1'b0;
      current_x_speed <= '0;
      current_y_speed <= '0;
    end else if (pub_load) begin
      speed_valid     <= 1'b1;
      current_x_speed <= dx;
      current_y_speed <= dy;
    end else if (pub_done) begin
      speed_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (overrun && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_speed_sample_sequencer.sv
// Self-checking bench for speed_sample_sequencer: transaction-level reference model
// compared every cycle, plus directed literal expectations per scenario.
module tb_speed_sample_sequencer;

  localparam int T = 8;
  localparam int W = 32;
  localparam longint SMAX = (longint'(1) << (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic signed [W-1:0] x_g = '0;
  logic signed [W-1:0] y_g = '0;
  logic speed_ready = 1'b1;
  logic sample_tick, speed_valid, busy, overrun;
  logic signed [W-1:0] current_x_speed, current_y_speed;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  speed_sample_sequencer #(.TICK_CYCLES(T), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .x_Global(x_g), .y_Global(y_g),
    .sample_tick(sample_tick), .speed_valid(speed_valid), .speed_ready(speed_ready),
    .current_x_speed(current_x_speed), .current_y_speed(current_y_speed),
    .busy(busy), .overrun(overrun), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint d);
    if (d > SMAX) return SMAX;
    if (d < SMIN) return SMIN;
    return d;
  endfunction

  // Reference model: tick phase, priming, and a pending publication with its age in cycles
  int     m_ph = 0;
  bit     m_primed = 0;
  bit     m_seq = 0;
  int     m_age = 0;
  int     m_drops = 0;
  longint m_prev_x = 0, m_prev_y = 0, m_pend_x = 0, m_pend_y = 0, m_out_x = 0, m_out_y = 0;

  always @(negedge clk) begin
    bit exp_tick, was_seq;
    if (!rst_n) begin
      chk("rst_valid", speed_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_xs", $signed(current_x_speed), 0);
      chk("rst_ys", $signed(current_y_speed), 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ovr", overrun, 0);
      m_ph = 0; m_primed = 0; m_seq = 0; m_age = 0; m_drops = 0;
      m_prev_x = 0; m_prev_y = 0; m_out_x = 0; m_out_y = 0;
    end else begin
      exp_tick = enable && (m_ph == T-1);
      chk("m_tick", sample_tick, exp_tick);
      chk("m_busy", busy, m_seq);
      chk("m_valid", speed_valid, m_seq && m_age >= 3);
      chk("m_overrun", overrun, exp_tick && m_seq);
      chk("m_drop", drop_cnt, m_drops);
      chk("m_xs", $signed(current_x_speed), m_out_x);
      chk("m_ys", $signed(current_y_speed), m_out_y);
      was_seq = m_seq;
      if (m_seq) begin
        if (m_age >= 3 && speed_ready)
          m_seq = 0;
        else begin
          if (m_age == 2) begin
            m_out_x = m_pend_x;
            m_out_y = m_pend_y;
          end
          m_age++;
        end
      end
      if (exp_tick) begin
        if (was_seq) begin
          if (m_drops < 255) m_drops++;
        end else if (!m_primed) begin
          m_prev_x = $signed(x_g); m_prev_y = $signed(y_g); m_primed = 1;
        end else begin
          m_pend_x = sat(longint'($signed(x_g)) - m_prev_x);
          m_pend_y = sat(longint'($signed(y_g)) - m_prev_y);
          m_prev_x = $signed(x_g); m_prev_y = $signed(y_g);
          m_seq = 1; m_age = 0;
        end
      end
      if (!enable) begin
        m_primed = 0; m_ph = 0;
      end else
        m_ph = (m_ph + 1) % T;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (!sample_tick && n < 100) begin
      step();
      n++;
    end
    if (!sample_tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic count_valid(input int cycles, output int v);
    v = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (speed_valid) v++;
    end
  endtask

  initial begin
    int n, v, ov;
    x_g = 100; y_g = -50;
    repeat (3) step();
    rst_n = 1'b1;

    // Priming then zero delta, 3-edge latency
    wait_tick(n);
    chk("first_tick_wait", n, 7);
    step();
    count_valid(7, v);
    chk("prime_no_valid", v, 0);
    wait_tick(n);
    step(); step(); step();
    chk("lat_e2_valid", speed_valid, 0);
    step();
    chk("lat_e3_valid", speed_valid, 1);
    chk("prime_xs", $signed(current_x_speed), 0);
    chk("prime_ys", $signed(current_y_speed), 0);
    x_g = 125; y_g = -57;

    // Constant step deltas, single-cycle valid
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      step();
      x_g = x_g + 25; y_g = y_g - 7;
      step(); step(); step();
      chk("delta_valid", speed_valid, 1);
      chk("delta_xs", $signed(current_x_speed), 25);
      chk("delta_ys", $signed(current_y_speed), -7);
      step();
      chk("delta_one_cycle", speed_valid, 0);
    end

    // Saturation at both rails
    wait_tick(n);
    step();
    x_g = 32'sh8000_0000; y_g = 32'sh7fff_ffff;
    wait_tick(n);
    step();
    x_g = 32'sh7fff_ffff; y_g = 32'sh8000_0000;
    wait_tick(n);
    step(); step(); step(); step();
    chk("sat_xs", $signed(current_x_speed), 64'sd2147483647);
    chk("sat_ys", $signed(current_y_speed), -64'sd2147483648);
    step();

    // Backpressure: two dropped ticks, delta spans three periods
    x_g = 0; y_g = 0; speed_ready = 1'b0;
    wait_tick(n);
    step();
    x_g = 75; y_g = -21;
    ov = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (overrun) ov++;
    end
    chk("bp_overruns", ov, 2);
    chk("bp_drop_cnt", drop_cnt, 2);
    chk("bp_valid_held", speed_valid, 1);
    speed_ready = 1'b1;
    step();
    wait_tick(n);
    step(); step(); step(); step();
    chk("bp_xs", $signed(current_x_speed), 75);
    chk("bp_ys", $signed(current_y_speed), -21);
    step();

    // Enable toggle: no ticks, counter restart, re-prime
    enable = 1'b0;
    v = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sample_tick) v++;
    end
    chk("dis_no_tick", v, 0);
    enable = 1'b1;
    x_g = 500; y_g = 500;
    wait_tick(n);
    chk("reen_tick_wait", n, 7);
    step();
    count_valid(7, v);
    chk("reen_prime_only", v, 0);

    // Async reset while in SUB_Y
    x_g = 520; y_g = 480;
    wait_tick(n);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", speed_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_xs", $signed(current_x_speed), 0);
    chk("arst_ys", $signed(current_y_speed), 0);
    chk("arst_drop", drop_cnt, 0);
    step();
    rst_n = 1'b1;
    wait_tick(n);
    chk("post_rst_tick_wait", n, 7);
    step();
    count_valid(7, v);
    chk("post_rst_prime_only", v, 0);
    x_g = 530;
    wait_tick(n);
    step(); step(); step(); step();
    chk("post_rst_xs", $signed(current_x_speed), 10);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/speed_sample_sequencer.md
Name: speed_sample_sequencer

Overview:
Periodic sampling controller for the chassis odometry datapath. It generates the 1 ms sample tick and snapshots both global position counters (x_Global, y_Global) on the same edge. It then computes the per-period deltas on one shared saturating subtractor and publishes the x/y speed pair to downstream control logic over a valid/ready handshake. It also reports overruns when the consumer stalls past the next tick.

Parameters:
TICK_CYCLES, 50000, clk cycles per sample period (1 ms at 50 MHz); legal range >= 8
W, 32, width of position inputs and speed outputs (signed)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  sampling enable; low holds tick counter at 0 and de-primes
x_Global  input  W  signed global X position count
y_Global  input  W  signed global Y position count
sample_tick  output  1  one-cycle pulse when cnt == TICK_CYCLES-1 and enable=1
speed_valid  output  1  speed pair available
speed_ready  input  1  consumer accepts the pair
current_x_speed  output  W  signed X delta, counts/period, saturated
current_y_speed  output  W  signed Y delta, counts/period, saturated
busy  output  1  FSM not in IDLE
overrun  output  1  one-cycle pulse when a tick is dropped
drop_cnt  output  8  dropped-tick count, saturates at 255

Behaviour:
- Reset, async on rst_n low. All outputs are 0, cnt = 0, primed = 0, FSM = IDLE, and the snapshot and previous registers are 0.
- Tick counter:
  - When enable = 1, cnt counts 0..TICK_CYCLES-1 and wraps.
  - sample_tick is combinational: (cnt == TICK_CYCLES-1) && enable.
  - When enable = 0, cnt is forced to 0 and primed is cleared. Any sequence already in progress completes normally, including the handshake.
- FSM states: IDLE, SUB_X, SUB_Y, PUBLISH.
  - IDLE with tick: cur_x/cur_y are loaded from the inputs on that edge (both axes in the same cycle).
    - If primed = 0: prev_x/prev_y are also loaded, primed is set, and the FSM stays in IDLE. Nothing is published.
    - Otherwise: go to SUB_X.
  - SUB_X: dx <= sat(cur_x - prev_x); go to SUB_Y.
  - SUB_Y: dy <= sat(cur_y - prev_y); prev <= cur; go to PUBLISH.
  - PUBLISH:
    - On entry edge: current_x_speed <= dx, current_y_speed <= dy, speed_valid <= 1.
    - Remain in PUBLISH while speed_valid && !speed_ready. Outputs are held stable during this time.
    - On speed_valid && speed_ready: speed_valid <= 0 at that edge and the FSM returns to IDLE.
- Latency: with the capture edge at E, speed_valid is first high after edge E+3. If speed_ready is held high, speed_valid is high for exactly one cycle. Minimum busy time is 4 cycles.
- Arithmetic and saturation:
  - Subtraction is done in W+1 bits.
  - Results above 2^(W-1)-1 clamp to 2^(W-1)-1.
  - Results below -2^(W-1) clamp to -2^(W-1).
  - Only one subtractor instance exists; the two axes are time-multiplexed across it.
- Overrun:
  - Raised when a tick occurs while the FSM is not in IDLE.
  - No snapshot is taken and prev is unchanged, so the next published delta spans multiple periods.
  - overrun pulses for 1 cycle and drop_cnt increments, saturating at 255.
  - drop_cnt is cleared only by reset.
- Outputs retain their last published values after the handshake completes.
- busy = (state != IDLE).
- Reset mid-operation aborts immediately to the reset state. primed is cleared, so the first tick after reset only primes.

Test Plan:
- Priming: TICK_CYCLES=8, enable=1, x=100, y=-50 held constant. The first tick produces no speed_valid. The second tick gives speed_valid with x_speed=0, y_speed=0 exactly 3 edges after the capture edge.
- Delta: with speed_ready=1, x stepping +25 and y stepping -7 per period. Each period publishes (25, -7); speed_valid is high for 1 cycle; sample_tick period is 8 cycles.
- Saturation: prev_x=-2^31, cur_x=2^31-1 gives x_speed=2^31-1. prev_y=2^31-1, cur_y=-2^31 gives y_speed=-2^31.
- Backpressure/overrun: speed_ready=0 for 20 cycles, TICK_CYCLES=8.
  - Outputs stay stable and speed_valid stays high.
  - overrun pulses twice and drop_cnt=2.
  - After ready: the next delta equals the position change over the multiple periods spanned by the dropped ticks.
- Enable toggle: enable=0 for 30 cycles, then 1. cnt restarts at 0, no sample_tick while disabled, and the first tick after re-enable only primes.
- Reset mid-sequence: assert rst_n=0 while in SUB_Y. All outputs are 0 immediately (async), drop_cnt=0, and the first subsequent tick produces no speed_valid.
